// File: rtl/uart_mul_pkg.sv
// Shared constants for the UART multiplier framing stage: FSM state codes,
// the default frame marker and a counter-width helper.
package uart_mul_pkg;

    // Default frame start marker.
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // FSM state encoding, kept as plain constants so legacy tools and
    // checkers can compare against the exposed state vector directly.
    localparam int         STATE_W    = 3;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RX_A    = 3'd1;
    localparam logic [2:0] ST_RX_B    = 3'd2;
    localparam logic [2:0] ST_MUL     = 3'd3;
    localparam logic [2:0] ST_TX_LOAD = 3'd4;
    localparam logic [2:0] ST_TX_ACK  = 3'd5;
    localparam logic [2:0] ST_TX_DONE = 3'd6;

    // Bits needed for a counter that must be able to hold max_val itself.
    function automatic int cnt_w(input int max_val);
        if (max_val < 2) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/seq_mul.sv
// Sequential unsigned shift-add multiplier. One partial product is added per
// cycle; the first one is folded into the start cycle so that done pulses
// exactly OP_W cycles after start and p holds the full 2*OP_W-bit product
// until the next start.
module seq_mul import uart_mul_pkg::*; #(
    parameter int OP_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [OP_W-1:0]     a,
    input  logic [OP_W-1:0]     b,
    output logic                done,
    output logic [2*OP_W-1:0]   p
);

    localparam int            CW        = cnt_w(OP_W);
    localparam logic [CW-1:0] LAST_STEP = CW'(OP_W - 1);

    logic [2*OP_W-1:0] mcand_q, mcand_d;
    logic [2*OP_W-1:0] acc_q, acc_d;
    logic [OP_W-1:0]   mplr_q, mplr_d;
    logic [CW-1:0]     step_q, step_d;
    logic              run_q, run_d;
    logic              done_q, done_d;
    logic [2*OP_W-1:0] a_ext;

    // Next-state: load and apply bit 0 on start, then one multiplier bit per cycle.
    always_comb begin
        mcand_d = mcand_q;
        acc_d   = acc_q;
        mplr_d  = mplr_q;
        step_d  = step_q;
        run_d   = run_q;
        done_d  = 1'b0;
        a_ext   = {{OP_W{1'b0}}, a};
        if (start) begin
            mcand_d = a_ext << 1;
            mplr_d  = b >> 1;
            acc_d   = b[0] ? a_ext : '0;
            step_d  = CW'(1);
            run_d   = 1'b1;
        end else if (run_q) begin
            if (mplr_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            step_d  = step_q + CW'(1);
            if (step_q == LAST_STEP) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Datapath and control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
            step_q  <= '0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mplr_q  <= mplr_d;
            step_q  <= step_d;
            run_q   <= run_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;
    assign p    = acc_q;

endmodule

// File: rtl/uart_mul_frame.sv
// Framing and compute stage between UART RX and UART TX. Collects
// SYNC + A + B (operands LSB byte first), multiplies them with seq_mul and
// streams the 2*OP_W-bit product back LSB byte first.
//
// Transmit handshake: tx_start is a one-cycle request, raised only while
// tx_ready=1; tx_data is valid with it and held until the transmitter has
// gone busy (tx_ready=0) and returned idle (tx_ready=1) again.
// OP_W must be a multiple of 8 and at least 8.
module uart_mul_frame import uart_mul_pkg::*; #(
    parameter int         OP_W        = 16,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_ready,
    output logic        busy,
    output logic        err_timeout,
    output logic        err_overrun,
    output logic [2:0]  dbg_state_o
);

    localparam int NB   = OP_W / 8;
    localparam int BC_W = cnt_w(NB);
    localparam int TM_W = cnt_w(TIMEOUT_CYC);
    localparam int IX_W = cnt_w(2 * NB);

    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NB - 1);
    localparam logic [TM_W-1:0] TMO_LIMIT = TM_W'(TIMEOUT_CYC);
    localparam logic [IX_W-1:0] LAST_IDX  = IX_W'(2 * NB - 1);

    logic [2:0]        state_q, state_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [TM_W-1:0]   tmo_q, tmo_d;
    logic [IX_W-1:0]   idx_q, idx_d;
    logic [OP_W-1:0]   a_q, a_d;
    logic [OP_W-1:0]   b_q, b_d;
    logic              err_tmo_q, err_ovr_q;
    logic              tmo_hit, ovr_hit, mul_start, mul_done;
    logic              is_sync;
    logic [OP_W-1:0]   a_shift, b_shift;
    logic [2*OP_W-1:0] mul_p;

    assign is_sync = rx_valid && (rx_data == SYNC_BYTE);
    // New byte enters at the top, so the first byte received ends up in the LSBs.
    assign a_shift = OP_W'({rx_data, a_q} >> 8);
    assign b_shift = OP_W'({rx_data, b_q} >> 8);

    // Frame FSM: byte collection, timeout abort, multiply wait and byte-wise TX.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        tmo_d      = tmo_q;
        idx_d      = idx_q;
        a_d        = a_q;
        b_d        = b_q;
        tmo_hit    = 1'b0;
        mul_start  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_sync) begin
                    state_d    = ST_RX_A;
                    byte_cnt_d = '0;
                    tmo_d      = '0;
                    a_d        = '0;
                    b_d        = '0;
                end
            end
            ST_RX_A, ST_RX_B: begin
                if (tmo_q == TMO_LIMIT) begin
                    // Abort wins over a same-cycle byte, which is then
                    // judged as if the block were already idle.
                    tmo_hit    = 1'b1;
                    a_d        = '0;
                    b_d        = '0;
                    byte_cnt_d = '0;
                    tmo_d      = '0;
                    state_d    = is_sync ? ST_RX_A : ST_IDLE;
                end else if (rx_valid) begin
                    tmo_d = '0;
                    if (state_q == ST_RX_A) begin
                        a_d = a_shift;
                    end else begin
                        b_d = b_shift;
                    end
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        if (state_q == ST_RX_A) begin
                            state_d = ST_RX_B;
                        end else begin
                            state_d   = ST_MUL;
                            mul_start = 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BC_W'(1);
                    end
                end else begin
                    tmo_d = tmo_q + TM_W'(1);
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_d = ST_TX_LOAD;
                    idx_d   = '0;
                end
            end
            ST_TX_LOAD: begin
                if (tx_ready) begin
                    state_d = ST_TX_ACK;
                end
            end
            ST_TX_ACK: begin
                if (!tx_ready) begin
                    state_d = ST_TX_DONE;
                end
            end
            ST_TX_DONE: begin
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IX_W'(1);
                        state_d = ST_TX_LOAD;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bytes arriving while computing or transmitting are dropped and flagged.
    assign ovr_hit = rx_valid && (state_q >= ST_MUL);

    // State, counters, operands and registered error pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            tmo_q      <= '0;
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            err_tmo_q  <= 1'b0;
            err_ovr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_q      <= tmo_d;
            idx_q      <= idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            err_tmo_q  <= tmo_hit;
            err_ovr_q  <= ovr_hit;
        end
    end

    // b_d carries the final B byte in the start cycle.
    seq_mul #(.OP_W(OP_W)) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (mul_start),
        .a     (a_q),
        .b     (b_d),
        .done  (mul_done),
        .p     (mul_p)
    );

    // Request is gated by reset so nothing is launched in a reset cycle.
    assign tx_start    = (state_q == ST_TX_LOAD) && tx_ready && !reset;
    assign tx_data     = 8'(mul_p >> {idx_q, 3'b000});
    assign busy        = (state_q != ST_IDLE);
    assign err_timeout = err_tmo_q;
    assign err_overrun = err_ovr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_mul_frame.sv
// Self-checking bench for uart_mul_frame (OP_W=16, TIMEOUT_CYC=100).
module tb_uart_mul_frame;

    localparam int OP_W    = 16;
    localparam int NB      = OP_W / 8;
    localparam int TMO     = 100;
    localparam int LATENCY = OP_W + 1;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_ready;
    logic       busy;
    logic       err_timeout;
    logic       err_overrun;
    logic [2:0] dbg_state;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int last_rx_cyc = 0;
    int tmo_pulses = 0;
    int ovr_pulses = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         start_cyc_q[$];

    uart_mul_frame #(.OP_W(OP_W), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset / bookkeeping ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (err_timeout === 1'b1) tmo_pulses <= tmo_pulses + 1;
        if (err_overrun === 1'b1) ovr_pulses <= ovr_pulses + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Transmitter model: captures each requested byte, goes busy 2 cycles
    // after the request and idle again 20 cycles later.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                got_q.push_back(tx_data);
                start_cyc_q.push_back(cyc);
                repeat (2) @(negedge clk);
                tx_ready = 1'b0;
                repeat (20) @(negedge clk);
                tx_ready = 1'b1;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [2*OP_W-1:0] ref_product(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
        return (2*OP_W)'(a) * (2*OP_W)'(b);
    endfunction

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        rx_data     = b;
        rx_valid    = 1'b1;
        last_rx_cyc = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic inject_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Sends one frame and queues the product bytes the model predicts.
    task automatic send_frame(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
        logic [2*OP_W-1:0] prod;
        prod = ref_product(a, b);
        for (int i = 0; i < 2 * NB; i++) exp_q.push_back(prod[8*i +: 8]);
        send_byte(8'hA5);
        for (int i = 0; i < NB; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < NB; i++) send_byte(b[8*i +: 8]);
    endtask

    task automatic wait_idle(input int max_cyc, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && tx_ready === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        start_cyc_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({tx_start, busy, err_timeout, err_overrun} !== 4'b0000 || tx_data !== 8'h00 || dbg_state !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got start=%b busy=%b tmo=%b ovr=%b data=%h state=%0d, expected all zero",
                     tx_start, busy, err_timeout, err_overrun, tx_data, dbg_state);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit to;
        logic [7:0] lit[4];
        logic [7:0] g;
        lit = '{8'h60, 8'h00, 8'h26, 8'h06};
        clear_sb();
        send_frame(16'h1234, 16'h5678);
        wait_idle(2000, to);
        tests_run++;
        if (to) begin tests_failed++; $display("FAIL basic_done: busy still %b, expected 0", busy); end
        tests_run++;
        if (start_cyc_q.size() == 0 || start_cyc_q[0] - last_rx_cyc != LATENCY) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d cycles, expected %0d",
                     (start_cyc_q.size() == 0) ? -1 : start_cyc_q[0] - last_rx_cyc, LATENCY);
        end
        tests_run++;
        if (got_q.size() != 4) begin tests_failed++; $display("FAIL basic_count: got %0d bytes, expected 4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            tests_run++;
            if (g !== lit[i] || g !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL basic_byte%0d: got %h expected %h", i, g, lit[i]);
            end
        end
    endtask

    task automatic test_max_zero();
        bit to;
        logic [7:0] lit[8];
        logic [7:0] g;
        lit = '{8'h01, 8'h00, 8'hFE, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        clear_sb();
        send_frame(16'hFFFF, 16'hFFFF);
        wait_idle(2000, to);
        send_frame(16'h0000, 16'hCDAB);
        wait_idle(2000, to);
        tests_run++;
        if (got_q.size() != 8 || to) begin tests_failed++; $display("FAIL max_count: got %0d bytes (timeout=%b), expected 8", got_q.size(), to); end
        for (int i = 0; i < 8; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            tests_run++;
            if (g !== lit[i] || g !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL max_byte%0d: got %h expected %h", i, g, lit[i]);
            end
        end
    endtask

    task automatic test_junk();
        bit to;
        int t0, o0;
        logic [7:0] lit[4];
        logic [7:0] g;
        lit = '{8'h06, 8'h00, 8'h00, 8'h00};
        clear_sb();
        t0 = tmo_pulses;
        o0 = ovr_pulses;
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h5A);
        repeat (10) @(negedge clk);
        tests_run++;
        if (got_q.size() != 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL junk_ignored: got %0d tx bytes busy=%b, expected 0 bytes busy=0", got_q.size(), busy);
        end
        send_frame(16'h0002, 16'h0003);
        wait_idle(2000, to);
        tests_run++;
        if (tmo_pulses != t0 || ovr_pulses != o0) begin
            tests_failed++;
            $display("FAIL junk_errors: got %0d timeout %0d overrun pulses, expected 0 0", tmo_pulses - t0, ovr_pulses - o0);
        end
        tests_run++;
        if (got_q.size() != 4 || to) begin tests_failed++; $display("FAIL junk_count: got %0d bytes, expected 4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            tests_run++;
            if (g !== lit[i]) begin tests_failed++; $display("FAIL junk_byte%0d: got %h expected %h", i, g, lit[i]); end
        end
    endtask

    task automatic test_timeout();
        bit to;
        int t0;
        logic [7:0] g;
        clear_sb();
        t0 = tmo_pulses;
        send_byte(8'hA5);
        send_byte(8'h34);
        repeat (TMO - 5) @(negedge clk);
        tests_run++;
        if (tmo_pulses != t0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_early: got %0d pulses busy=%b, expected 0 pulses busy=1", tmo_pulses - t0, busy);
        end
        repeat (60) @(negedge clk);
        tests_run++;
        if (tmo_pulses - t0 != 1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_pulse: got %0d pulses busy=%b, expected 1 pulse busy=0", tmo_pulses - t0, busy);
        end
        send_frame(16'h1234, 16'h5678);
        wait_idle(2000, to);
        tests_run++;
        if (got_q.size() != 4 || to) begin tests_failed++; $display("FAIL timeout_count: got %0d bytes, expected 4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            tests_run++;
            if (g !== exp_q[i]) begin tests_failed++; $display("FAIL timeout_byte%0d: got %h expected %h", i, g, exp_q[i]); end
        end
    endtask

    task automatic test_overrun();
        bit to;
        bit seen;
        int o0, t0;
        logic [7:0] g;
        clear_sb();
        o0 = ovr_pulses;
        t0 = tmo_pulses;
        send_frame(16'h1234, 16'h5678);
        repeat (3) @(negedge clk);
        inject_byte(8'h77);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (dbg_state === 3'd5) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        if (seen) inject_byte(8'h77);
        tests_run++;
        if (!seen) begin tests_failed++; $display("FAIL overrun_ack_wait: got no TX_ACK within 200 cycles, expected state 5"); end
        wait_idle(2000, to);
        tests_run++;
        if (ovr_pulses - o0 != 2 || tmo_pulses != t0) begin
            tests_failed++;
            $display("FAIL overrun_pulses: got %0d overrun %0d timeout, expected 2 0", ovr_pulses - o0, tmo_pulses - t0);
        end
        tests_run++;
        if (got_q.size() != 4 || to) begin tests_failed++; $display("FAIL overrun_count: got %0d bytes, expected 4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            tests_run++;
            if (g !== exp_q[i]) begin tests_failed++; $display("FAIL overrun_byte%0d: got %h expected %h", i, g, exp_q[i]); end
        end
    endtask

    task automatic test_random();
        bit to;
        logic [OP_W-1:0] a, b;
        logic [7:0] g;
        clear_sb();
        // Sync value inside operand data must be taken as data.
        send_frame(16'hA5A5, 16'h00A5);
        wait_idle(2000, to);
        for (int f = 0; f < 4; f++) begin
            a = OP_W'($urandom_range(0, 65535));
            b = OP_W'($urandom_range(0, 65535));
            send_frame(a, b);
            wait_idle(2000, to);
        end
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL random_count: got %0d bytes, expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            tests_run++;
            if (g !== exp_q[i]) begin tests_failed++; $display("FAIL random_byte%0d: got %h expected %h", i, g, exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_tx();
        bit to;
        bit seen;
        logic [7:0] g;
        clear_sb();
        send_frame(16'h1234, 16'h5678);
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (got_q.size() >= 2) begin seen = 1'b1; break; end
        end
        tests_run++;
        if (!seen) begin tests_failed++; $display("FAIL rst_tx_wait: got %0d bytes, expected 2 before reset", got_q.size()); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if ({tx_start, busy, err_timeout, err_overrun} !== 4'b0000 || tx_data !== 8'h00 || dbg_state !== 3'd0) begin
            tests_failed++;
            $display("FAIL rst_tx_outputs: got start=%b busy=%b tmo=%b ovr=%b data=%h state=%0d, expected all zero",
                     tx_start, busy, err_timeout, err_overrun, tx_data, dbg_state);
        end
        repeat (60) @(negedge clk);
        tests_run++;
        if (got_q.size() != 2 || got_q[0] !== 8'h60 || got_q[1] !== 8'h00) begin
            tests_failed++;
            $display("FAIL rst_tx_stream: got %0d bytes, expected exactly 60 00", got_q.size());
        end
        clear_sb();
        send_frame(16'h0102, 16'h0304);
        wait_idle(2000, to);
        tests_run++;
        if (got_q.size() != 4 || to) begin tests_failed++; $display("FAIL rst_new_count: got %0d bytes, expected 4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            tests_run++;
            if (g !== exp_q[i]) begin tests_failed++; $display("FAIL rst_new_byte%0d: got %h expected %h", i, g, exp_q[i]); end
        end
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        test_reset();
        test_basic();
        test_max_zero();
        test_junk();
        test_timeout();
        test_overrun();
        test_random();
        test_reset_mid_tx();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
